// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths and the requester state encoding.
package apb_pkg;
    localparam int APB_AW = 32;
    localparam int APB_DW = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;
endpackage

// File: rtl/apb_master.sv
// Single-outstanding APB requester: one valid/ready command becomes one
// SETUP/ACCESS transfer and one response, with a bounded ACCESS wait.
module apb_master
    import apb_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [APB_AW-1:0] cmd_addr,
    input  logic [APB_DW-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [APB_DW-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [APB_AW-1:0] paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [APB_DW-1:0] pwdata,
    input  logic [APB_DW-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);
    localparam bit         TO_EN   = (TIMEOUT != 0);
    localparam logic [7:0] TO_LAST = TO_EN ? 8'(TIMEOUT - 1) : 8'd0;

    apb_state_e        state_q, state_d;
    logic [7:0]        wait_q, wait_d;
    logic [APB_AW-1:0] paddr_q, paddr_d;
    logic              pwrite_q, pwrite_d;
    logic [APB_DW-1:0] pwdata_q, pwdata_d;
    logic [APB_DW-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            wait_q   <= '0;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    paddr_d  = {cmd_addr[APB_AW-1:2], 2'b00};
                    pwrite_d = cmd_write;
                    pwdata_d = cmd_wdata;
                    wait_d   = '0;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                wait_d  = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                // pready is checked first so a completion on the final wait cycle is not an error
                if (pready) begin
                    rdata_d = pwrite_q ? '0 : prdata;
                    err_d   = pslverr;
                    state_d = RESP;
                end else if (TO_EN && (wait_q == TO_LAST)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready = (state_q == IDLE);
    assign psel      = (state_q == SETUP) || (state_q == ACCESS);
    assign penable   = (state_q == ACCESS);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign paddr     = paddr_q;
    assign pwrite    = pwrite_q;
    assign pwdata    = pwdata_q;
endmodule

// File: doc/apb_master.md
# apb_master

Single-outstanding APB requester that converts a simple valid/ready command interface into APB setup/access transfers and returns one response per command. It is the initiator counterpart to the team's APB completers: the LED controller and future peripheral register blocks. It lets the game/AI logic read and write peripheral registers without a processor. Each transfer has a bounded wait so that a stuck completer cannot hang the requester.

## Interface
- `TIMEOUT`, 16 — maximum ACCESS cycles with `pready` low before the transfer is forced to finish with an error; 0 disables the timeout. Legal range is 0–255.
- `clk` input 1 — single clock; all state changes on the rising edge.
- `rst` input 1 — reset, synchronous and active-low (0 = reset).
- `cmd_valid` input 1 — command request.
- `cmd_ready` output 1 — command accepted when high with `cmd_valid`.
- `cmd_write` input 1 — 1 = write, 0 = read.
- `cmd_addr` input 32 — byte address; bits [1:0] are ignored.
- `cmd_wdata` input 32 — write data.
- `rsp_valid` output 1 — response available.
- `rsp_ready` input 1 — response consumed when high with `rsp_valid`.
- `rsp_rdata` output 32 — read data; 0 for writes and for timeouts.
- `rsp_err` output 1 — `pslverr` was returned, or the timeout fired.
- `paddr` output 32 — APB address; bits [1:0] are always 0.
- `psel` output 1 — APB select.
- `penable` output 1 — APB enable.
- `pwrite` output 1 — APB direction.
- `pwdata` output 32 — APB write data.
- `prdata` input 32 — APB read data.
- `pready` input 1 — APB ready.
- `pslverr` input 1 — APB error; sampled only when `pready` is 1 in ACCESS.

## Operation
- FSM states: IDLE → SETUP → ACCESS → RESP → IDLE.
- **IDLE**
  - `cmd_ready` = 1 in IDLE only; it is combinational from the state.
  - On `cmd_valid`, register the address (`paddr` = {`cmd_addr`[31:2], 2'b00}), `pwrite` and `pwdata`, then go to SETUP.
- **SETUP**
  - `psel` = 1, `penable` = 0.
  - Unconditionally go to ACCESS.
- **ACCESS**
  - `psel` = 1, `penable` = 1.
  - If `pready` = 1:
    - Capture `rsp_rdata` = `prdata` for a read, or 0 for a write.
    - Capture `rsp_err` = `pslverr`.
    - Go to RESP.
  - Else, if `TIMEOUT` ≠ 0 and the wait counter equals `TIMEOUT` − 1:
    - `rsp_rdata` = 0, `rsp_err` = 1.
    - Go to RESP.
  - Else increment the wait counter.
- **RESP**
  - `psel` = 0, `penable` = 0, `rsp_valid` = 1.
  - The response is held stable until `rsp_ready`, then go to IDLE.
- APB outputs (`paddr`, `pwrite`, `pwdata`) stay stable from SETUP through the end of ACCESS, and keep their last value afterwards.
- The wait counter is 8 bits. It clears on entry to SETUP and is never compared when `TIMEOUT` = 0.
- `cmd_*` inputs are ignored outside IDLE. At most one transfer is outstanding.
- **Reset** (`rst` = 0 at an edge), including mid-transfer:
  - State returns to IDLE.
  - `psel`, `penable`, `pwrite`, `rsp_valid`, `rsp_err` = 0.
  - `paddr`, `pwdata`, `rsp_rdata` = 0.
  - The wait counter = 0.
  - Any in-flight response is discarded.

## Timing
- Cycle 0: the `cmd_valid` & `cmd_ready` edge.
- Cycle 1: SETUP.
- Cycle 2: ACCESS.
- With an always-ready completer, `rsp_valid` rises at cycle 3.
- Minimum command-to-command spacing is 4 cycles (0 → 4) when `rsp_ready` is tied high.
- Each wait state adds one ACCESS cycle.
- With the timeout enabled, ACCESS lasts exactly `TIMEOUT` cycles when `pready` stays low, and `rsp_valid` rises the cycle after.
- If `pready` = 1 on the same cycle the counter reaches `TIMEOUT` − 1, it is a normal completion: `pready` wins, with no timeout error.
- `psel` is never high in two back-to-back transfers without an intervening low cycle; the RESP/IDLE cycles guarantee this.

## Structure
- A shared package `apb_pkg` holds:
  - localparams `APB_AW` = 32 and `APB_DW` = 32;
  - the state encoding: IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, RESP = 2'd3.
- No sub-module is required. The FSM, wait counter and response registers live in one module.

## Test plan
- **Write, no wait:** write 0x0000_00A5 to address 0x4 against an always-ready completer.
  - `paddr` = 0x4, `pwdata` = 0xA5, `pwrite` = 1.
  - SETUP at cycle 1, ACCESS at cycle 2.
  - `rsp_valid` at cycle 3 with `rsp_err` = 0 and `rsp_rdata` = 0.
- **Read with wait states:** read address 0x7, with `pready` low for 3 ACCESS cycles and `prdata` = 0x5A.
  - `paddr` = 0x4.
  - ACCESS lasts 4 cycles.
  - `rsp_rdata` = 0x5A, `rsp_err` = 0.
- **Completer error:** `pslverr` = 1 together with `pready`.
  - `rsp_err` = 1.
  - The next command is accepted after `rsp_ready`.
- **Timeout:** `TIMEOUT` = 4 and `pready` held 0.
  - ACCESS lasts exactly 4 cycles.
  - `rsp_err` = 1, `rsp_rdata` = 0.
  - `psel` = 0 on the following cycle.
- **Response backpressure:** hold `rsp_ready` = 0 for 5 cycles.
  - `rsp_valid`, `rsp_rdata` and `rsp_err` are stable.
  - `cmd_ready` = 0 until one cycle after `rsp_ready`.
- **Reset mid-ACCESS:** assert `rst` = 0 at the edge during ACCESS.
  - Next cycle: `psel` = `penable` = `rsp_valid` = 0 and `cmd_ready` = 1 after `rst` returns to 1.
  - No response is emitted.
